// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types and sizing for the NTT input packer.
//
// Contents:
//   DATA_WIDTH_PER_INPUT  coefficient width in bits
//   INPUT_PER_CYCLE       coefficients per wide beat (lanes)
//   POLY_DEGREE           coefficients per polynomial (multiple of INPUT_PER_CYCLE)
//   START_FANOUT          replicated start bits driven to the core
//   BEATS                 wide beats per polynomial (calc_beats)
//   coeff_t               one coefficient
//   idx_t / beat_t        coefficient index / beat index
//   rd_state_e            read-side FSM state {IDLE, STREAM}
package ntt_pkg;

  localparam int DATA_WIDTH_PER_INPUT = 28;
  localparam int INPUT_PER_CYCLE      = 128;
  localparam int POLY_DEGREE          = 1024;
  localparam int START_FANOUT         = 9;

  function automatic int calc_beats(input int poly_degree, input int per_cycle);
    return poly_degree / per_cycle;
  endfunction

  localparam int BEATS  = calc_beats(POLY_DEGREE, INPUT_PER_CYCLE);
  localparam int IDX_W  = $clog2(POLY_DEGREE);
  localparam int LANE_W = $clog2(INPUT_PER_CYCLE);
  localparam int BEAT_W = $clog2(BEATS);

  typedef logic [DATA_WIDTH_PER_INPUT-1:0] coeff_t;
  typedef logic [IDX_W-1:0]                idx_t;
  typedef logic [BEAT_W-1:0]               beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/ntt_poly_bank.sv
// ntt_poly_bank: storage for one complete polynomial.
//
// Coefficient k lives at address k; a wide read returns beat k/INPUT_PER_CYCLE
// with lane j holding coefficient (beat*INPUT_PER_CYCLE + j). Storage is not
// reset: contents are only meaningful once the owning bank is marked full.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   coefficient index to write
//   wdata  in   coefficient value
//   raddr  in   beat index to read
//   rdata  out  INPUT_PER_CYCLE coefficients of the addressed beat (combinational)
module ntt_poly_bank
  import ntt_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  idx_t   waddr,
  input  coeff_t wdata,
  input  beat_t  raddr,
  output coeff_t rdata [INPUT_PER_CYCLE]
);

  coeff_t mem [POLY_DEGREE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Beat index forms the upper address bits, lane number the lower bits.
  always_comb begin
    for (int j = 0; j < INPUT_PER_CYCLE; j++) begin
      rdata[j] = mem[{raddr, LANE_W'(j)}];
    end
  end

endmodule

// File: rtl/ntt_input_packer.sv
// ntt_input_packer: serial coefficient stream -> ping-pong polynomial buffer
// -> wide beats to the NTT core.
//
// Optional feature: define NTT_PACKER_LAST_CHECK_EN to check s_last against the
// write index on every handshake. A mismatch drops the partial polynomial and
// sets the sticky frame_err. Without the macro s_last is ignored and frame_err
// is tied low.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-low reset
//   s_valid    in   input coefficient valid
//   s_ready    out  packer can accept a coefficient
//   s_data     in   coefficient, natural order, index 0 first
//   s_last     in   marks coefficient POLY_DEGREE-1 (checked only with the macro)
//   out_data   out  wide beat, INPUT_PER_CYCLE lanes, zero when out_valid is low
//   out_valid  out  out_data carries a beat
//   out_start  out  START_FANOUT copies of the start strobe, high on beat 0 only
//   frame_err  out  sticky framing error
//   dbg_state  out  current read-side FSM state
//
// Handshake: a coefficient transfers on a rising edge where s_valid and s_ready
// are both high. s_ready depends only on registered state (never on s_valid);
// the sender must hold s_data/s_last stable while s_valid is high and not
// accepted. The output side has no back-pressure: once beat 0 leaves, all
// BEATS beats follow on consecutive cycles.
module ntt_input_packer
  import ntt_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      s_valid,
  output logic      s_ready,
  input  coeff_t    s_data,
  input  logic      s_last,
  output coeff_t    out_data [INPUT_PER_CYCLE],
  output logic      out_valid,
  output logic      out_start [START_FANOUT],
  output logic      frame_err,
  output rd_state_e dbg_state
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic      wr_bank;
  idx_t      wr_idx;
  logic      rd_bank;
  beat_t     rd_beat;   // next beat to emit while in STREAM
  logic [1:0] full;
  rd_state_e state;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic wr_fire;
  logic wr_last;
  logic last_bad;
  logic wr_commit;

  assign s_ready   = !full[wr_bank];
  assign wr_fire   = s_valid && s_ready;
  assign wr_last   = (wr_idx == IDX_W'(POLY_DEGREE - 1));
  assign wr_commit = wr_fire && wr_last && !last_bad;

`ifdef NTT_PACKER_LAST_CHECK_EN
  logic frame_err_q;

  // s_last must be high exactly on the final coefficient of a polynomial.
  assign last_bad  = (s_last != wr_last);
  assign frame_err = frame_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else if (wr_fire && last_bad) begin
      frame_err_q <= 1'b1;
    end
  end
`else
  logic unused_last;

  assign unused_last = s_last;
  assign last_bad    = 1'b0;
  assign frame_err   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read side control signals
  // ---------------------------------------------------------------------------
  logic  rd_go;       // start condition seen from IDLE
  logic  rd_done;     // last beat of the current polynomial is being emitted
  logic  emit;        // a beat is registered onto the outputs this edge
  beat_t beat_sel;    // beat index presented to the bank read ports

  assign rd_go    = full[rd_bank];
  assign rd_done  = (state == STREAM) && (rd_beat == BEAT_W'(BEATS - 1));
  assign emit     = ((state == IDLE) && rd_go) || (state == STREAM);
  assign beat_sel = (state == STREAM) ? rd_beat : '0;

  // ---------------------------------------------------------------------------
  // Pointers, counters and full flags. The reader clears its bank in the same
  // edge the writer may be sampling s_ready; s_ready reflects the clear one
  // cycle later because it only looks at the registered flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      full    <= 2'b00;
    end else begin
      if (rd_done) begin
        full[rd_bank] <= 1'b0;
      end
      if (wr_fire) begin
        if (last_bad) begin
          wr_idx <= '0;
        end else if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Banks
  // ---------------------------------------------------------------------------
  coeff_t rdata0 [INPUT_PER_CYCLE];
  coeff_t rdata1 [INPUT_PER_CYCLE];

  ntt_poly_bank u_bank0 (
    .clk   (clk),
    .we    (wr_fire && !wr_bank),
    .waddr (wr_idx),
    .wdata (s_data),
    .raddr (beat_sel),
    .rdata (rdata0)
  );

  ntt_poly_bank u_bank1 (
    .clk   (clk),
    .we    (wr_fire && wr_bank),
    .waddr (wr_idx),
    .wdata (s_data),
    .raddr (beat_sel),
    .rdata (rdata1)
  );

  // ---------------------------------------------------------------------------
  // Read FSM with registered outputs. Beat 0 is emitted on the same edge that
  // leaves IDLE, so a polynomial completed at edge t appears after edge t+1.
  // On the last beat, if the other bank is already full, the FSM stays in
  // STREAM and beat 0 of that bank follows with no gap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_beat   <= '0;
      out_valid <= 1'b0;
      for (int j = 0; j < INPUT_PER_CYCLE; j++) begin
        out_data[j] <= '0;
      end
      for (int i = 0; i < START_FANOUT; i++) begin
        out_start[i] <= 1'b0;
      end
    end else begin
      out_valid <= emit;
      for (int j = 0; j < INPUT_PER_CYCLE; j++) begin
        if (!emit) begin
          out_data[j] <= '0;
        end else if (rd_bank) begin
          out_data[j] <= rdata1[j];
        end else begin
          out_data[j] <= rdata0[j];
        end
      end
      for (int i = 0; i < START_FANOUT; i++) begin
        out_start[i] <= emit && (beat_sel == '0);
      end

      case (state)
        IDLE: begin
          if (rd_go) begin
            state   <= STREAM;
            rd_beat <= BEAT_W'(1);
          end
        end
        STREAM: begin
          if (rd_done) begin
            rd_bank <= ~rd_bank;
            rd_beat <= '0;
            state   <= full[~rd_bank] ? STREAM : IDLE;
          end else begin
            rd_beat <= rd_beat + BEAT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ntt_input_packer.sv
// tb_ntt_input_packer: directed bench for ntt_input_packer.
// Builds with or without NTT_PACKER_LAST_CHECK_EN; the framing step adapts.
module tb_ntt_input_packer;
  import ntt_pkg::*;

  localparam int W  = DATA_WIDTH_PER_INPUT * INPUT_PER_CYCLE;
  localparam int DW = DATA_WIDTH_PER_INPUT;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      s_valid = 1'b0;
  logic      s_ready;
  coeff_t    s_data = '0;
  logic      s_last = 1'b0;
  coeff_t    out_data [INPUT_PER_CYCLE];
  logic      out_valid;
  logic      out_start [START_FANOUT];
  logic      frame_err;
  rd_state_e dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc_cyc = 0;
  int first_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  ntt_input_packer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_start (out_start),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard storage
  // ---------------------------------------------------------------------------
  logic [W-1:0]            exp_q[$];
  logic [W-1:0]            cap_q[$];
  logic [START_FANOUT-1:0] cap_start_q[$];
  int                      cap_cyc_q[$];

  function automatic logic [W-1:0] pack_out();
    logic [W-1:0] r;
    for (int j = 0; j < INPUT_PER_CYCLE; j++) r[j*DW +: DW] = out_data[j];
    return r;
  endfunction

  function automatic logic [START_FANOUT-1:0] pack_start();
    logic [START_FANOUT-1:0] r;
    for (int i = 0; i < START_FANOUT; i++) r[i] = out_start[i];
    return r;
  endfunction

  // Monitor: capture every beat; idle cycles must show zero data and start.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      cap_q.push_back(pack_out());
      cap_start_q.push_back(pack_start());
      cap_cyc_q.push_back(cyc);
    end else begin
      total++;
      assert ((pack_out() === '0) && (pack_start() === '0)) else begin
        bad++;
        $error("FAIL idle_zero: observed nonzero data/start=%0h while out_valid low at cycle %0d, expected 0",
               pack_start(), cyc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic send_poly(input int offset, input int count, input int last_at, input bit gap);
    int n;
    for (int k = 0; k < count; k++) begin
      if (gap) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = coeff_t'(offset + k);
      s_last  = (k == last_at);
      n = 0;
      while (s_ready !== 1'b1 && n < 4000) begin
        @(negedge clk);
        n++;
      end
      total++;
      assert (n < 4000) else begin
        bad++;
        $error("FAIL ready_timeout: observed s_ready low for %0d cycles at k=%0d, expected high", n, k);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(negedge clk);
      last_acc_cyc = cyc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_poly(input int offset);
    logic [W-1:0] b_exp;
    for (int b = 0; b < BEATS; b++) begin
      for (int j = 0; j < INPUT_PER_CYCLE; j++) begin
        b_exp[j*DW +: DW] = coeff_t'(offset + b*INPUT_PER_CYCLE + j);
      end
      exp_q.push_back(b_exp);
    end
  endtask

  // Compare captured beats against exp_q; contig_n beats from the start must be
  // back-to-back even across polynomial boundaries.
  task automatic check_stream(input string tag, input int contig_n, output int first);
    int n;
    int fl;
    int prev;
    logic [W-1:0] o;
    logic [W-1:0] e;
    logic [START_FANOUT-1:0] st;
    int c;
    n = exp_q.size();
    first = -1;
    chk({tag, "_count"}, cap_q.size(), n);
    if (cap_q.size() != n) begin
      exp_q.delete();
      cap_q.delete();
      cap_start_q.delete();
      cap_cyc_q.delete();
      return;
    end
    prev = 0;
    for (int i = 0; i < n; i++) begin
      o  = cap_q.pop_front();
      e  = exp_q.pop_front();
      st = cap_start_q.pop_front();
      c  = cap_cyc_q.pop_front();
      if (i == 0) first = c;
      fl = 0;
      for (int j = INPUT_PER_CYCLE - 1; j >= 0; j--) begin
        if (o[j*DW +: DW] !== e[j*DW +: DW]) fl = j;
      end
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s_data beat %0d lane %0d: observed=%0h expected=%0h",
               tag, i, fl, o[fl*DW +: DW], e[fl*DW +: DW]);
      end
      chk($sformatf("%s_start%0d", tag, i), 32'(st),
          (i % BEATS == 0) ? 32'((1 << START_FANOUT) - 1) : 32'd0);
      if (i > 0 && ((i % BEATS) != 0 || i < contig_n)) begin
        chk($sformatf("%s_contig%0d", tag, i), c, prev + 1);
      end
      prev = c;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_start", 32'(pack_start()), 0);
    chk("rst_data_or", 32'(|pack_out()), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(s_ready), 1);

    // Single polynomial, continuous input, latency check
    expect_poly(0);
    send_poly(0, POLY_DEGREE, POLY_DEGREE - 1, 1'b0);
    repeat (15) @(negedge clk);
    check_stream("single", BEATS, first_cyc);
    chk("single_latency", first_cyc, last_acc_cyc + 1);

    // Gapped input, 50% valid
    expect_poly(32'h60000);
    send_poly(32'h60000, POLY_DEGREE, POLY_DEGREE - 1, 1'b1);
    repeat (15) @(negedge clk);
    check_stream("gapped", BEATS, first_cyc);

    // Back-pressure: reader held off while two banks fill
    force dut.rd_go = 1'b0;
    expect_poly(32'h10000);
    expect_poly(32'h20000);
    send_poly(32'h10000, POLY_DEGREE, POLY_DEGREE - 1, 1'b0);
    send_poly(32'h20000, POLY_DEGREE, POLY_DEGREE - 1, 1'b0);
    chk("bp_ready_low", 32'(s_ready), 0);
    repeat (20) @(negedge clk);
    chk("bp_ready_still_low", 32'(s_ready), 0);
    chk("bp_no_beats", cap_q.size(), 0);
    release dut.rd_go;
    expect_poly(32'h30000);
    send_poly(32'h30000, POLY_DEGREE, POLY_DEGREE - 1, 1'b0);
    repeat (20) @(negedge clk);
    check_stream("bp", 2 * BEATS, first_cyc);

    // Reset mid-fill
    send_poly(32'h70000, 500, -1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_start", 32'(pack_start()), 0);
    chk("mid_rst_data_or", 32'(|pack_out()), 0);
    chk("mid_rst_frame_err", 32'(frame_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(s_ready), 1);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    expect_poly(32'h80000);
    send_poly(32'h80000, POLY_DEGREE, POLY_DEGREE - 1, 1'b0);
    repeat (15) @(negedge clk);
    check_stream("after_rst", BEATS, first_cyc);

    // Framing
`ifdef NTT_PACKER_LAST_CHECK_EN
    send_poly(32'h90000, 701, 700, 1'b0);
    @(negedge clk);
    chk("frame_err_set", 32'(frame_err), 1);
    repeat (10) @(negedge clk);
    chk("frame_no_beats", cap_q.size(), 0);
    expect_poly(32'hA0000);
    send_poly(32'hA0000, POLY_DEGREE, POLY_DEGREE - 1, 1'b0);
    repeat (15) @(negedge clk);
    check_stream("frame_next", BEATS, first_cyc);
    chk("frame_err_sticky", 32'(frame_err), 1);
`else
    expect_poly(32'h90000);
    send_poly(32'h90000, POLY_DEGREE, 700, 1'b0);
    expect_poly(32'hA0000);
    send_poly(32'hA0000, POLY_DEGREE, POLY_DEGREE - 1, 1'b0);
    repeat (15) @(negedge clk);
    check_stream("last_ignored", BEATS, first_cyc);
    chk("frame_err_tied", 32'(frame_err), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_input_packer.md
# ntt_input_packer

Upstream feeder for the NTT top level. Accepts one polynomial coefficient per cycle over a valid/ready stream, assembles complete polynomials in a two-bank ping-pong buffer, and replays each polynomial to the NTT core as POLY_DEGREE/INPUT_PER_CYCLE consecutive wide beats, with the core's start vector asserted on the first beat. The core has no back-pressure, so once a replay begins it never stalls; all flow control happens on the serial input side.

## Interface
- DATA_WIDTH_PER_INPUT, 28, coefficient width in bits.
- INPUT_PER_CYCLE, 128, coefficients per wide beat (lanes).
- POLY_DEGREE, 1024, coefficients per polynomial; an integer multiple of INPUT_PER_CYCLE.
- START_FANOUT, 9, number of replicated start bits driven to the core.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  input coefficient valid.
- s_ready  out  1  packer can accept a coefficient.
- s_data  in  DATA_WIDTH_PER_INPUT  coefficient, natural order, index 0 first.
- s_last  in  1  marks coefficient POLY_DEGREE-1 (checked only with the config macro).
- out_data  out  DATA_WIDTH_PER_INPUT x INPUT_PER_CYCLE, unpacked array  wide beat to the core.
- out_valid  out  1  out_data carries a beat.
- out_start  out  1 x START_FANOUT, unpacked array  all bits high on beat 0 of a polynomial only.
- frame_err  out  1  sticky framing error.

## Operation
- BEATS = POLY_DEGREE/INPUT_PER_CYCLE. Coefficient k goes to beat k/INPUT_PER_CYCLE, lane k%INPUT_PER_CYCLE.
- Write side: wr_bank pointer, wr_idx counter 0..POLY_DEGREE-1. s_ready = !full[wr_bank], combinational from registered state.
- On each handshake (s_valid && s_ready): store the coefficient and increment wr_idx.
- Handshake at wr_idx = POLY_DEGREE-1: set full[wr_bank], toggle wr_bank, wrap wr_idx to 0.
- Read FSM:
  - IDLE -> STREAM when full[rd_bank] is set.
  - STREAM drives beats 0..BEATS-1 on consecutive cycles.
  - After the last beat: clear full[rd_bank], toggle rd_bank, then STREAM again if the other bank is full, otherwise IDLE.
- out_data is zero whenever out_valid is low.
- Simultaneous clear of full by the reader and a write-side check of the same bank: the clear is seen by s_ready the following cycle. There is no same-cycle bypass.
- Reset:
  - Asserting rst clears wr_bank, rd_bank, wr_idx, full[], FSM (IDLE), and frame_err.
  - All outputs go to 0, except s_ready, which becomes 1 after release.
  - Bank storage is not reset. A polynomial interrupted mid-fill or mid-stream is discarded.

## Timing
- Outputs out_data, out_valid, and out_start are registered.
- Latency: final coefficient accepted at edge t, reader IDLE: beat 0 is valid during the cycle after edge t+1; beats are contiguous for BEATS cycles.
- Sustained throughput: 1 coefficient/cycle. Replay of 8 beats is far shorter than a 1024-cycle fill, so s_ready only drops when both banks are full.
- out_start and out_valid both rise in the same cycle as beat 0.

## Configuration
- NTT_PACKER_LAST_CHECK_EN defined:
  - s_last is compared against wr_idx == POLY_DEGREE-1 on every handshake.
  - On a mismatch, frame_err sets (sticky until reset), the partial polynomial is dropped, and wr_idx returns to 0 without marking the bank full.
- Undefined: s_last is ignored and frame_err is tied to 0.

## Structure
- Shared package ntt_pkg:
  - coeff_t (DATA_WIDTH_PER_INPUT-bit logic).
  - BEATS localparam function.
  - Read FSM state enum {IDLE, STREAM}.
- Sub-module ntt_poly_bank, one per bank:
  - Holds POLY_DEGREE coefficients.
  - Write port addressed by coefficient index; read port returns one full beat by beat index.
- Top level holds the pointers, counters, FSM, and optional check.

## Test plan
- Single polynomial: drive s_data = k for k = 0..1023 with s_valid held high -> 8 consecutive beats; beat b lane j = 128b+j; out_start is all ones only on beat 0; first beat one cycle after the edge following acceptance of k = 1023.
- Back-pressure: send 3 polynomials with the reader prevented from draining (force the core-side check to IDLE via a bench hook) -> s_ready is 0 after 2048 accepts; no data lost once draining resumes.
- Gapped input: s_valid toggling 50 % over one polynomial -> identical beat contents; out_valid is contiguous for 8 cycles.
- Reset mid-fill: assert rst after 500 coefficients, then send a full polynomial 0..1023 -> only the new polynomial is replayed; all outputs are 0 during reset.
- With NTT_PACKER_LAST_CHECK_EN: s_last asserted at k = 700 -> frame_err = 1; no beats emitted; the next correct polynomial streams normally and frame_err stays 1.
